// File: rtl/cpu_pkg.sv
// Shared pipeline types for the writeback/resolve stage.
// Holds datapath widths, control bundle and source-select helpers.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 6;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_wrt;
    logic pc_to_reg;
    logic branch_z;
    logic branch_n;
    logic jump;
    logic jump_mem;
  } wb_ctrl_t;

  typedef enum logic [1:0] {
    MEM,
    ALU,
    PCY
  } wb_src_e;

  typedef enum logic {
    SQ_IDLE,
    SQ_BUSY
  } sq_state_e;

  // PC+y outranks memory, which outranks the ALU result.
  function automatic wb_src_e wb_src(wb_ctrl_t c);
    wb_src_e s;
    s = ALU;
    if (c.pc_to_reg) s = PCY;
    else if (c.mem_to_reg) s = MEM;
    return s;
  endfunction

  function automatic logic wb_taken(
    wb_ctrl_t c,
    logic     n,
    logic     z
  );
    return c.jump_mem | c.jump
         | (c.branch_z & z)
         | (c.branch_n & n);
  endfunction

endpackage

// File: rtl/wb_squash_ctr.sv
// Wrong-path squash counter: loads SQUASH_CYCLES on a taken
// redirect and counts down once per clock while busy.
module wb_squash_ctr
  import cpu_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic busy_o
);

  localparam int CW = 3;

  sq_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SQ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Loads are ignored while busy; the window is never extended.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SQ_IDLE: begin
        if (load_i) begin
          cnt_d   = CW'(SQUASH_CYCLES);
          state_d = SQ_BUSY;
        end
      end
      SQ_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = SQ_IDLE;
      end
      default: begin
        state_d = SQ_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == SQ_BUSY);

endmodule

// File: rtl/wb_resolve.sv
// Writeback select, branch/jump resolution and squash stage.
// Define WB_PERF_CNT_EN to add retired_cnt/taken_cnt counters.
module wb_resolve
  import cpu_pkg::wb_ctrl_t;
  import cpu_pkg::wb_src_e;
  import cpu_pkg::MEM;
  import cpu_pkg::ALU;
  import cpu_pkg::PCY;
  import cpu_pkg::wb_src;
  import cpu_pkg::wb_taken;
#(
  parameter int DATA_W        = cpu_pkg::DATA_W,
  parameter int REG_AW        = cpu_pkg::REG_AW,
  parameter int SQUASH_CYCLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              n_in,
  input  logic              z_in,
  input  logic              mem_to_reg,
  input  logic              reg_wrt,
  input  logic              pc_to_reg,
  input  logic              branch_z,
  input  logic              branch_n,
  input  logic              jump,
  input  logic              jump_mem,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] pc_y,
  input  logic [REG_AW-1:0] rd,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              redirect,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
`ifdef WB_PERF_CNT_EN
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  taken_cnt,
`endif
  output logic              squashing
);

  wb_ctrl_t          ctrl;
  wb_src_e           src;
  logic              busy;
  logic              accept;
  logic              taken;
  logic              we_d;
  logic              redir_d;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] target_d;

  logic              rf_we_q;
  logic [REG_AW-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              redirect_q;
  logic              flush_q;
  logic [DATA_W-1:0] pc_target_q;
  logic              fwd_valid_q;
  logic [REG_AW-1:0] fwd_rd_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic              squashing_q;

  always_comb begin
    ctrl = '{
      mem_to_reg: mem_to_reg,
      reg_wrt:    reg_wrt,
      pc_to_reg:  pc_to_reg,
      branch_z:   branch_z,
      branch_n:   branch_n,
      jump:       jump,
      jump_mem:   jump_mem
    };
    src     = wb_src(ctrl);
    taken   = wb_taken(ctrl, n_in, z_in);
    accept  = in_valid & ~busy;
    we_d    = accept & ctrl.reg_wrt;
    redir_d = accept & taken;

    wdata_d = alu_out;
    unique case (src)
      MEM:     wdata_d = mem_out;
      ALU:     wdata_d = alu_out;
      PCY:     wdata_d = pc_y;
      default: wdata_d = alu_out;
    endcase

    target_d = alu_out;
    unique case (1'b1)
      ctrl.jump_mem: target_d = mem_out;
      default:       target_d = alu_out;
    endcase
  end

  wb_squash_ctr #(
    .SQUASH_CYCLES (SQUASH_CYCLES)
  ) u_sq (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (redir_d),
    .busy_o (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      redirect_q  <= 1'b0;
      flush_q     <= 1'b0;
      pc_target_q <= '0;
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= '0;
      fwd_data_q  <= '0;
      squashing_q <= 1'b0;
    end else begin
      rf_we_q     <= we_d;
      redirect_q  <= redir_d;
      flush_q     <= redir_d;
      squashing_q <= busy;
      if (we_d) begin
        rf_waddr_q  <= rd;
        rf_wdata_q  <= wdata_d;
        fwd_valid_q <= 1'b1;
        fwd_rd_q    <= rd;
        fwd_data_q  <= wdata_d;
      end
      if (redir_d) pc_target_q <= target_d;
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] taken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      taken_q   <= '0;
    end else begin
      if (accept)  retired_q <= retired_q + CNT_W'(1);
      if (redir_d) taken_q   <= taken_q + CNT_W'(1);
    end
  end

  assign retired_cnt = retired_q;
  assign taken_cnt   = taken_q;
`endif

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign redirect  = redirect_q;
  assign flush     = flush_q;
  assign pc_target = pc_target_q;
  assign fwd_valid = fwd_valid_q;
  assign fwd_rd    = fwd_rd_q;
  assign fwd_data  = fwd_data_q;
  assign squashing = squashing_q;

endmodule

// File: tb/tb_wb_resolve.sv
// Bench for wb_resolve: vector table applied through an
// expected-result queue, plus reset and counter sequences.
module tb_wb_resolve;

  logic        clk;
  logic        rst_n;
  logic        in_valid, n_in, z_in;
  logic        mem_to_reg, reg_wrt, pc_to_reg;
  logic        branch_z, branch_n, jump, jump_mem;
  logic [31:0] mem_out, alu_out, pc_y;
  logic [5:0]  rd;
  logic        rf_we, redirect, flush, fwd_valid, squashing;
  logic [5:0]  rf_waddr, fwd_rd;
  logic [31:0] rf_wdata, pc_target, fwd_data;
`ifdef WB_PERF_CNT_EN
  logic [31:0] retired_cnt, taken_cnt;
`endif

  wb_resolve dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .n_in       (n_in),
    .z_in       (z_in),
    .mem_to_reg (mem_to_reg),
    .reg_wrt    (reg_wrt),
    .pc_to_reg  (pc_to_reg),
    .branch_z   (branch_z),
    .branch_n   (branch_n),
    .jump       (jump),
    .jump_mem   (jump_mem),
    .mem_out    (mem_out),
    .alu_out    (alu_out),
    .pc_y       (pc_y),
    .rd         (rd),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .redirect   (redirect),
    .pc_target  (pc_target),
    .flush      (flush),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data),
`ifdef WB_PERF_CNT_EN
    .retired_cnt(retired_cnt),
    .taken_cnt  (taken_cnt),
`endif
    .squashing  (squashing)
  );

  typedef struct {
    logic        v, n, z, m2r, rw, p2r, bz, bn, j, jm;
    logic [31:0] mem, alu, pcy;
    logic [5:0]  rd;
    logic        e_we;
    logic [5:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rd;
    logic [31:0] e_tg;
    logic        e_sq;
  } vec_t;

  int          checks;
  int          failures;
  vec_t        exp_q[$];
  vec_t        tbl[17];
  logic        f_v;
  logic [5:0]  f_rd;
  logic [31:0] f_d;
  int          exp_ret;
  int          exp_tk;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(
    logic v, logic n, logic z, logic m2r, logic rw,
    logic p2r, logic bz, logic bn, logic j, logic jm,
    logic [31:0] mem, logic [31:0] alu,
    logic [31:0] pcy, logic [5:0] rdv,
    logic ewe, logic [5:0] ewa, logic [31:0] ewd,
    logic erd, logic [31:0] etg, logic esq
  );
    vec_t t;
    t.v = v; t.n = n; t.z = z; t.m2r = m2r;
    t.rw = rw; t.p2r = p2r; t.bz = bz; t.bn = bn;
    t.j = j; t.jm = jm; t.mem = mem; t.alu = alu;
    t.pcy = pcy; t.rd = rdv; t.e_we = ewe;
    t.e_wa = ewa; t.e_wd = ewd; t.e_rd = erd;
    t.e_tg = etg; t.e_sq = esq;
    return t;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input vec_t t);
    in_valid   = t.v;
    n_in       = t.n;
    z_in       = t.z;
    mem_to_reg = t.m2r;
    reg_wrt    = t.rw;
    pc_to_reg  = t.p2r;
    branch_z   = t.bz;
    branch_n   = t.bn;
    jump       = t.j;
    jump_mem   = t.jm;
    mem_out    = t.mem;
    alu_out    = t.alu;
    pc_y       = t.pcy;
    rd         = t.rd;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".we"}, 32'(rf_we), 0);
    chk({tag, ".wa"}, 32'(rf_waddr), 0);
    chk({tag, ".wd"}, rf_wdata, 0);
    chk({tag, ".redir"}, 32'(redirect), 0);
    chk({tag, ".flush"}, 32'(flush), 0);
    chk({tag, ".tgt"}, pc_target, 0);
    chk({tag, ".fv"}, 32'(fwd_valid), 0);
    chk({tag, ".frd"}, 32'(fwd_rd), 0);
    chk({tag, ".fd"}, fwd_data, 0);
    chk({tag, ".sq"}, 32'(squashing), 0);
`ifdef WB_PERF_CNT_EN
    chk({tag, ".ret"}, retired_cnt, 0);
    chk({tag, ".tk"}, taken_cnt, 0);
`endif
  endtask

  // Drive on the falling edge, compare on the next falling edge.
  task automatic run(input vec_t t, input string nm);
    vec_t e;
    set_in(t);
    exp_q.push_back(t);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({nm, ".queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, ".we"}, 32'(rf_we), 32'(e.e_we));
      chk({nm, ".redir"}, 32'(redirect), 32'(e.e_rd));
      chk({nm, ".flush"}, 32'(flush), 32'(e.e_rd));
      chk({nm, ".sq"}, 32'(squashing), 32'(e.e_sq));
      if (e.e_we) begin
        chk({nm, ".wa"}, 32'(rf_waddr), 32'(e.e_wa));
        chk({nm, ".wd"}, rf_wdata, e.e_wd);
        f_v  = 1'b1;
        f_rd = e.e_wa;
        f_d  = e.e_wd;
      end
      if (e.e_rd) chk({nm, ".tgt"}, pc_target, e.e_tg);
      if (e.v && !e.e_sq) exp_ret++;
      if (e.e_rd) exp_tk++;
      chk({nm, ".fv"}, 32'(fwd_valid), 32'(f_v));
      if (f_v) begin
        chk({nm, ".frd"}, 32'(fwd_rd), 32'(f_rd));
        chk({nm, ".fd"}, fwd_data, f_d);
      end
    end
  endtask

  task automatic chk_cnt(input string nm);
`ifdef WB_PERF_CNT_EN
    chk({nm, ".ret"}, retired_cnt, 32'(exp_ret));
    chk({nm, ".tk"}, taken_cnt, 32'(exp_tk));
`else
    chk({nm, ".ret_model"}, 32'(exp_ret), 32'(exp_ret));
    checks--;
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    f_v      = 1'b0;
    f_rd     = '0;
    f_d      = '0;
    exp_ret  = 0;
    exp_tk   = 0;

    //        v n z m2 rw p2 bz bn j jm mem     alu     pcy   rd
    tbl[0]  = mk(1,0,0,0,1,0,0,0,0,0, 0,'h12,0,5,
                 1,5,'h12, 0,0, 0);
    tbl[1]  = mk(1,0,0,1,1,1,0,0,0,0, 'h99,'h1,'h40,7,
                 1,7,'h40, 0,0, 0);
    tbl[2]  = mk(1,0,0,1,1,0,0,0,0,0, 'h99,'h1,'h40,8,
                 1,8,'h99, 0,0, 0);
    tbl[3]  = mk(1,0,0,0,1,0,0,0,0,0, 0,'h55,0,0,
                 1,0,'h55, 0,0, 0);
    tbl[4]  = mk(1,1,1,0,1,0,0,0,0,0, 0,'h66,0,6,
                 1,6,'h66, 0,0, 0);
    tbl[5]  = mk(1,1,0,0,0,0,0,1,0,0, 0,'h100,0,1,
                 0,0,0, 1,'h100, 0);
    tbl[6]  = mk(1,0,0,0,1,0,0,0,0,0, 0,'h1,0,9,
                 0,0,0, 0,0, 1);
    tbl[7]  = mk(1,0,0,0,1,0,0,0,0,0, 0,'h2,0,10,
                 0,0,0, 0,0, 1);
    tbl[8]  = mk(1,0,0,0,1,0,0,0,0,0, 0,'h3,0,11,
                 1,11,'h3, 0,0, 0);
    tbl[9]  = mk(1,0,0,0,1,0,1,0,0,0, 0,'h44,0,12,
                 1,12,'h44, 0,0, 0);
    tbl[10] = mk(1,0,0,0,1,0,0,0,1,1, 'h200,'h300,0,13,
                 1,13,'h300, 1,'h200, 0);
    tbl[11] = mk(1,0,0,0,1,0,0,0,1,0, 0,'h400,0,2,
                 0,0,0, 0,0, 1);
    tbl[12] = mk(0,0,0,0,1,0,0,0,0,0, 0,'h9,0,3,
                 0,0,0, 0,0, 1);
    tbl[13] = mk(1,0,0,0,1,0,0,0,0,0, 0,'h5,0,14,
                 1,14,'h5, 0,0, 0);
    tbl[14] = mk(0,0,0,0,1,0,0,0,0,0, 0,'h6,0,15,
                 0,0,0, 0,0, 0);
    tbl[15] = mk(1,0,1,0,0,0,1,0,0,0, 0,'h80,0,1,
                 0,0,0, 1,'h80, 0);
    tbl[16] = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,
                 0,0,0, 0,0, 1);

    // Reset held with a writing bundle present.
    rst_n = 1'b0;
    set_in(mk(1,0,0,0,1,0,0,0,1,0, 'h7,'h7,'h7,3,
              0,0,0, 0,0, 0));
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run(tbl[i], $sformatf("v%0d", i));
    end
    chk_cnt("tbl");

    // Reset pulse while one squash cycle is still pending.
    set_in(mk(1,0,0,0,1,0,0,0,0,0, 0,'h77,0,20,
              0,0,0, 0,0, 0));
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    f_v     = 1'b0;
    exp_ret = 0;
    exp_tk  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(mk(1,0,0,0,1,0,0,0,0,0, 0,'h77,0,20,
           1,20,'h77, 0,0, 0), "post");
    run(mk(1,0,0,0,1,0,0,0,0,0, 0,'h21,0,21,
           1,21,'h21, 0,0, 0), "pw1");
    run(mk(1,0,0,1,1,0,0,0,0,0, 'h22,0,0,22,
           1,22,'h22, 0,0, 0), "pw2");
    run(mk(1,1,0,0,0,0,0,1,0,0, 0,'h180,0,0,
           0,0,0, 1,'h180, 0), "pbr");
    run(mk(1,0,0,0,1,0,0,0,0,0, 0,'h23,0,23,
           0,0,0, 0,0, 1), "ps1");
    run(mk(1,0,0,0,1,0,0,0,0,0, 0,'h24,0,24,
           0,0,0, 0,0, 1), "ps2");
    chk_cnt("perf");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_resolve.md
# wb_resolve

Writeback and control-resolution stage directly downstream of the EX/WB pipeline register. Each cycle it takes one EX/WB bundle and selects the register-file write data (memory, ALU or PC+y). It resolves BRZ/BRN/J/JM into a PC redirect and squashes the wrong-path bundles that follow a taken redirect. It also presents a one-entry forwarding record of the last retired write to the ID/EX bypass logic.

## Interface
Parameters:
- DATA_W, 32, datapath and PC width
- REG_AW, 6, register address width (64 registers)
- SQUASH_CYCLES, 2, bundles discarded after a taken redirect (1..7)
- CNT_W, 32, performance counter width (used only with the macro)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  bundle from EX/WB is a real instruction
- n_in, z_in  in  1 each  ALU negative/zero flags
- mem_to_reg, reg_wrt, pc_to_reg  in  1 each  writeback controls
- branch_z, branch_n, jump, jump_mem  in  1 each  control-flow controls
- mem_out  in  DATA_W  data-memory read value
- alu_out  in  DATA_W  ALU result; also the register-sourced target for J/BRZ/BRN
- pc_y  in  DATA_W  PC+y value for SVPC
- rd  in  REG_AW  destination register
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  DATA_W  write data
- redirect  out  1  one-cycle pulse: load pc_target into PC
- pc_target  out  DATA_W  redirect address
- flush  out  1  one-cycle pulse: clear IF/ID and ID/EX bundles
- fwd_valid  out  1  forwarding record valid
- fwd_rd  out  REG_AW  last written register
- fwd_data  out  DATA_W  last written value
- squashing  out  1  stage is discarding bundles

## Operation
- Accepted bundle: in_valid=1 and squash counter is 0.
- Write data: pc_to_reg ? pc_y : (mem_to_reg ? mem_out : alu_out).
- rf_we = accepted & reg_wrt. There is no hardwired zero register; rd=0 writes normally.
- Taken condition: jump_mem | jump | (branch_z & z_in) | (branch_n & n_in).
- Target priority: jump_mem selects mem_out. Otherwise jump, branch_z or branch_n select alu_out.
- An accepted taken bundle pulses redirect and flush, and loads the squash counter with SQUASH_CYCLES.
- A taken bundle may also write a register (e.g. reg_wrt set alongside jump); the write still occurs.
- States:
  - IDLE (count 0).
  - SQUASH (count >0): every clock decrements the counter, whether or not in_valid is set.
  - While squashing, no write, redirect or flush is issued, and the squash counter is not reloaded.
  - SQUASH returns to IDLE when the counter reaches 0.
  - The bundle presented on the cycle the counter becomes 0 is accepted.
- Forwarding record:
  - Updated with waddr/wdata on every rf_we.
  - Held otherwise.
  - fwd_valid is set by the first write and stays 1 until reset.
- Non-taken control bundle, e.g. branch_z with z_in=0: no redirect, no squash, write as normal.

## Timing
- Inputs are sampled on the rising clk edge. EX/WB updates on the falling edge, so inputs have been stable for half a cycle.
- All outputs are registered, with 1-cycle latency from sample to rf_we/redirect/flush/fwd_*.
- redirect and flush are high for exactly one cycle per taken bundle.
- squashing is high on the SQUASH_CYCLES cycles after the redirect pulse.
- Reset (async, rst_n=0) takes effect immediately:
  - all outputs 0, squash counter 0, fwd_valid 0, counters 0;
  - pc_target, rf_wdata, fwd_data 0.
- Reset mid-squash cancels the squash. The first bundle after rst_n deasserts is accepted.
- Back-to-back taken bundles: the second falls in the squash window and is discarded.

## Configuration
- WB_PERF_CNT_EN defined:
  - adds outputs retired_cnt and taken_cnt, each CNT_W bits, reset 0;
  - retired_cnt increments on each accepted bundle;
  - taken_cnt increments on each redirect;
  - both wrap modulo 2^CNT_W.
- Not defined: neither port nor the counter logic exists. All other behaviour is identical.

## Structure
- Shared package cpu_pkg:
  - DATA_W and REG_AW constants;
  - wb_ctrl_t packed struct (mem_to_reg, reg_wrt, pc_to_reg, branch_z, branch_n, jump, jump_mem);
  - wb_src_e enum (MEM, ALU, PCY).
- One sub-module, wb_squash_ctr: down-counter with load and busy output, parameterised by SQUASH_CYCLES.
- The write-data and target muxes stay inline.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 and reg_wrt=1 -> all outputs 0; after release, first bundle accepted.
- ALU write: reg_wrt=1, alu_out=0x12, rd=5 -> next cycle rf_we=1, waddr=5, wdata=0x12, fwd_rd=5, fwd_data=0x12.
- Source select:
  - pc_to_reg=1, mem_to_reg=1, pc_y=0x40, mem_out=0x99 -> wdata=0x40;
  - with pc_to_reg=0 -> wdata=0x99.
- Branch taken and not taken:
  - branch_n=1, n_in=1, alu_out=0x100 -> redirect=1, pc_target=0x100, flush=1;
  - the next 2 bundles (reg_wrt=1) produce rf_we=0, and the third writes;
  - branch_z=1, z_in=0 -> no redirect.
- Priority and collision:
  - jump_mem=1, jump=1, mem_out=0x200, alu_out=0x300 -> pc_target=0x200;
  - a second jump in the squash window is ignored;
  - rst_n pulsed low mid-squash -> squashing=0 and the next bundle is accepted.
- WB_PERF_CNT_EN: 3 writes then 1 taken branch -> retired_cnt=4, taken_cnt=1; squashed bundles are not counted.
